// File: rtl/sftm_group_packer.sv
// Packs the SFTM group stream (one word per cycle) into wide packets of up to
// GROUP_ROWS words. Packets are queued in a small FIFO toward the QMU, with
// drop and malformed-group status reported alongside.
module sftm_group_packer #(
  parameter int DATA_W     = 16,
  parameter int GROUP_ROWS = 4,
  parameter int DEPTH      = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic                                bypass_mode,
  output logic [GROUP_ROWS*DATA_W-1:0]        out_data,
  output logic [$clog2(GROUP_ROWS+1)-1:0]     out_count,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overflow,
  output logic                                no_last_err,
  output logic [7:0]                          drop_cnt,
  output logic [15:0]                         pkt_cnt
);

  localparam int CNT_W = $clog2(GROUP_ROWS + 1);
  localparam int PKT_W = GROUP_ROWS * DATA_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PKT_W-1:0] asm_data;
  logic [CNT_W-1:0] asm_cnt;
  logic             asm_byp;

  logic             byp_eff;
  logic             at_full_row;
  logic             close;
  logic [PKT_W-1:0] pkt_data;
  logic [CNT_W-1:0] pkt_count;

  logic [PKT_W-1:0] mem_data [DEPTH];
  logic [CNT_W-1:0] mem_cnt  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             drop;

  // Mode is taken live from bypass_mode only on the first word of a group.
  always_comb begin
    byp_eff     = (asm_cnt == '0) ? bypass_mode : asm_byp;
    pkt_count   = asm_cnt + CNT_W'(1);
    at_full_row = (pkt_count == CNT_W'(GROUP_ROWS));
    close       = in_valid && (byp_eff || in_last || at_full_row);
    pkt_data    = asm_data;
    for (int k = 0; k < GROUP_ROWS; k++) begin
      if (asm_cnt == CNT_W'(k)) begin
        pkt_data[k*DATA_W +: DATA_W] = in_data;
      end
    end
  end

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !fifo_empty && out_ready;
    push       = close && (!fifo_full || pop);
    drop       = close && !push;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_data    <= '0;
      asm_cnt     <= '0;
      asm_byp     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      no_last_err <= 1'b0;
      drop_cnt    <= '0;
      pkt_cnt     <= '0;
    end else begin
      if (in_valid && (asm_cnt == '0)) begin
        asm_byp <= bypass_mode;
      end
      if (close) begin
        asm_data <= '0;
        asm_cnt  <= '0;
      end else if (in_valid) begin
        asm_data <= pkt_data;
        asm_cnt  <= pkt_count;
      end
      if (close && !byp_eff && !in_last && at_full_row) begin
        no_last_err <= 1'b1;
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= pkt_data;
      mem_cnt[wr_ptr[AW-1:0]]  <= pkt_count;
    end
  end

  always_comb begin
    out_valid = !fifo_empty;
    out_data  = out_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
    out_count = out_valid ? mem_cnt[rd_ptr[AW-1:0]]  : '0;
  end

endmodule

// File: doc/sftm_group_packer.md
# sftm_group_packer

Downstream stage of the SFTM core. Consumes the SFTM's one-word-per-cycle group stream and assembles each group of up to GROUP_ROWS words into one wide packet. Packets are queued in a small output FIFO and drained toward the QMU/writeback over a valid/ready handshake. The block also reports dropped groups and malformed groups.

## Interface
- DATA_W, 16, width of one group word
- GROUP_ROWS, 4, maximum words per group (≥2)
- DEPTH, 2, output FIFO entries (power of 2, ≥2)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset; synchronous, active-low
- in_data  in  DATA_W  group word (driven by SFTM group_data)
- in_valid  in  1  word strobe (SFTM group_data_valid); no backpressure, every strobe is consumed
- in_last  in  1  last word of group (SFTM group_done); only meaningful when in_valid=1
- bypass_mode  in  1  emit each word as its own 1-word packet
- out_data  out  GROUP_ROWS*DATA_W  packet; word k in bits [k*DATA_W +: DATA_W], unused lanes zero
- out_count  out  $clog2(GROUP_ROWS+1)  number of valid words in packet (1..GROUP_ROWS)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- overflow  out  1  sticky: a packet was dropped because the FIFO was full
- no_last_err  out  1  sticky: a group reached GROUP_ROWS words without in_last
- drop_cnt  out  8  dropped-packet count, saturates at 255
- pkt_cnt  out  16  packets accepted into FIFO, wraps

## Operation
- Assembly register: asm_data (GROUP_ROWS*DATA_W), asm_cnt (0..GROUP_ROWS), asm_byp (mode latched for the current group).
- Mode sampling: when asm_cnt==0, an incoming word latches asm_byp=bypass_mode. While asm_cnt>0, bypass_mode is ignored until the group closes.
- Word accept (in_valid=1): write in_data into lane asm_cnt and increment asm_cnt.
- The group closes on the same accepting cycle when any of these holds:
  - asm_byp=1 (every word closes; count=1).
  - in_last=1: short or exact group; count=asm_cnt+1.
  - asm_cnt+1==GROUP_ROWS without in_last: close and set no_last_err.
- An in_last arriving exactly at GROUP_ROWS is a normal close.
- On close:
  - The packet (data, count) is pushed to the FIFO.
  - asm_data and asm_cnt are cleared, so lanes of the next packet that are never written read as zero.
- A word arriving the cycle after a close starts a new group. Back-to-back groups run with no gap.
- Push to a full FIFO:
  - The packet is discarded, overflow←1, drop_cnt += 1 (saturating), pkt_cnt unchanged.
  - Exception: if a pop happens in the same cycle (out_valid && out_ready), the push succeeds.
- Pop: on out_valid && out_ready the head advances.
- FIFO pointers are log2(DEPTH)+1 bits and wrap. Full and empty are distinguished by the MSB.
- Push and pop in the same cycle on a non-full FIFO leaves the occupancy unchanged.
- in_last with in_valid=0 is ignored.
- Reset mid-operation clears the assembly register, the FIFO, and all status. Partial groups are discarded.

## Timing
- Reset values: out_data=0, out_count=0, out_valid=0, overflow=0, no_last_err=0, drop_cnt=0, pkt_cnt=0.
- Latency: closing word at edge N. If the FIFO was empty, out_valid=1 after edge N+1, with out_data/out_count valid in the same cycle. pkt_cnt increments at edge N+1.
- out_data and out_count are driven from FIFO storage at the head pointer. They hold stable while out_valid && !out_ready.
- out_valid deasserts the cycle after the last entry pops, unless a push lands at the same edge.
- Sustained throughput: one packet per cycle in bypass, one per group otherwise.
- Sticky flags clear only on reset.

## Test plan
- Normal group, DEPTH=2, out_ready=1: words 0,1,2,3 with in_last on word 3 → one packet 0x0003_0002_0001_0000, count=4, out_valid one cycle after word 3, pkt_cnt=1.
- Short group: words 0xAAAA, 0xBBBB with in_last on the 2nd → data 0x0000_0000_BBBB_AAAA, count=2, no_last_err=0.
- Missing last: 5 words 1..5, no in_last → packet {4,3,2,1} count=4 with no_last_err=1. Then word 5 with in_last → packet 0x...0005, count=1.
- Backpressure: out_ready=0, three 4-word groups.
  - First two queued; the third is dropped, giving overflow=1, drop_cnt=1, pkt_cnt=2.
  - Raise out_ready → packets 1 and 2 emerge in order with held data.
- Full FIFO with simultaneous pop: FIFO full, third group closes in the same cycle out_ready=1 pops → no drop, pkt_cnt=3.
- Bypass and reset:
  - bypass_mode=1, words 7,8 → two packets, count=1 each.
  - Toggling bypass mid-group has no effect until the group closes.
  - Assert rst_n=0 with 2 words assembled and 1 queued → all outputs zero next cycle. The queued packet never appears.
